// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction-word assembler: packs decoded fields into a 32-bit word
// and flags immediates the selected format cannot represent.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // stage 1: raw fields
  logic        s1_valid;
  logic [2:0]  s1_type;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;

  // stage 2: encoded word
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;

  logic        s2_load;
  logic        accept;
  logic        handshake;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !flush && (!s1_valid || s2_load);
  assign accept    = in_valid && in_ready;
  assign handshake = s2_valid && out_ready && !flush;

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;

  // an immediate fits N signed bits when everything above bit N-2 matches the sign bit
  assign fits_12 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign fits_13 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
  assign fits_21 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (s1_type)
      FMT_R: begin
        enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      end
      FMT_I: begin
        enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_err  = !fits_12;
      end
      FMT_S: begin
        enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        enc_err  = !fits_12;
      end
      FMT_B: begin
        enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                    s1_imm[4:1], s1_imm[11], s1_opcode};
        enc_err  = !fits_13 || s1_imm[0];
      end
      FMT_U: begin
        enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
        enc_err  = |s1_imm[11:0];
      end
      FMT_J: begin
        enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        enc_err  = !fits_21 || s1_imm[0];
      end
      default: begin
        enc_word = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_type   <= 3'd0;
      s1_opcode <= 7'd0;
      s1_rd     <= 5'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_funct3 <= 3'd0;
      s1_funct7 <= 7'd0;
      s1_imm    <= 32'h0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_type   <= in_type;
      s1_opcode <= in_opcode;
      s1_rd     <= in_rd;
      s1_rs1    <= in_rs1;
      s1_rs2    <= in_rs2;
      s1_funct3 <= in_funct3;
      s1_funct7 <= in_funct7;
      s1_imm    <= in_imm;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_instr <= 32'h0;
      s2_err   <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_instr <= enc_err ? 32'h0 : enc_word;
      s2_err   <= enc_err;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (handshake) begin
      enc_count <= enc_count + CNT_W'(1);
      if (s2_err) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, error flags, latency, backpressure,
// flush and asynchronous reset.
module tb_instr_encoder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_type;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_enc = 0;
  int exp_err = 0;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_fields(input logic [2:0] t, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // one isolated transfer with out_ready=1; reports the word and whether latency was 2
  task automatic xfer(input logic [2:0] t, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      output logic [31:0] w, output logic e, output logic lat_ok);
    logic acc, v1, v2;
    set_fields(t, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v1 = out_valid;
    @(posedge clk); #1;
    v2 = out_valid;
    w = out_instr;
    e = out_err;
    @(posedge clk); #1;
    lat_ok = acc && !v1 && v2;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b instr=%h err=%b want 0/0/0", out_valid, out_instr, out_err);
    end
    n_cmp++;
    if (enc_count !== 16'd0 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_counts: got enc=%0d err=%0d want 0/0", enc_count, err_count);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_i_type();
    logic [31:0] w; logic e, lat;
    xfer(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'hFFF1_0093 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL i_word: got %h err=%b want fff10093 err=0", w, e);
    end
    n_cmp++;
    if (lat !== 1'b1) begin
      n_bad++;
      $display("FAIL i_latency: got ok=%b want 1", lat);
    end
    n_cmp++;
    if (enc_count !== 16'(exp_enc)) begin
      n_bad++;
      $display("FAIL i_enc_count: got %0d want %0d", enc_count, exp_enc);
    end
  endtask

  task automatic test_s_b();
    logic [31:0] w; logic e, lat;
    xfer(3'd2, 7'h23, 5'd0, 5'd10, 5'd5, 3'd2, 7'd0, 32'd8, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'h0055_2423 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL s_word: got %h err=%b want 00552423 err=0", w, e);
    end
    xfer(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'hFE00_0EE3 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL b_neg_word: got %h err=%b want fe000ee3 err=0", w, e);
    end
    xfer(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'h0000_0363 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL b_pos_word: got %h err=%b want 00000363 err=0", w, e);
    end
  endtask

  task automatic test_j_u_r();
    logic [31:0] w; logic e, lat;
    xfer(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'h0010_00EF || e !== 1'b0) begin
      n_bad++;
      $display("FAIL j_word: got %h err=%b want 001000ef err=0", w, e);
    end
    xfer(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'h1234_52B7 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL u_word: got %h err=%b want 123452b7 err=0", w, e);
    end
    xfer(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'h4031_00B3 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL r_word: got %h err=%b want 403100b3 err=0", w, e);
    end
  endtask

  task automatic test_errors();
    logic [2:0]  types [4] = '{3'd1, 3'd3, 3'd4, 3'd7};
    logic [31:0] imms  [4] = '{32'h0000_0800, 32'd3, 32'h1234_5001, 32'h0};
    logic [31:0] w; logic e, lat;
    for (int i = 0; i < 4; i++) begin
      xfer(types[i], 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, imms[i], w, e, lat);
      exp_enc++; exp_err++;
      n_cmp++;
      if (w !== 32'h0 || e !== 1'b1) begin
        n_bad++;
        $display("FAIL err_vec%0d: got %h err=%b want 00000000 err=1", i, w, e);
      end
      n_cmp++;
      if (err_count !== 16'(exp_err) || enc_count !== 16'(exp_enc)) begin
        n_bad++;
        $display("FAIL err_count%0d: got err=%0d enc=%0d want %0d/%0d", i, err_count, enc_count, exp_err, exp_enc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3] = '{32'h0000_0093, 32'h0000_0113, 32'h0000_0193};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        set_fields(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_instr !== want[i-2]) begin
          n_bad++;
          $display("FAIL b2b_word%0d: got valid=%b %h want 1 %h", i - 2, out_valid, out_instr, want[i-2]);
        end
      end
      @(posedge clk); #1;
    end
    exp_enc += 3;
    n_cmp++;
    if (out_valid !== 1'b0 || enc_count !== 16'(exp_enc)) begin
      n_bad++;
      $display("FAIL b2b_drain: got valid=%b enc=%0d want 0/%0d", out_valid, enc_count, exp_enc);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want [3] = '{32'h0000_0093, 32'h0000_0113, 32'h0000_0193};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fields(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== (i < 2)) begin
        n_bad++;
        $display("FAIL bp_ready%0d: got %b want %b", i, in_ready, (i < 2));
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_instr !== want[0] || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got valid=%b %h ready=%b want 1 %h 0", k, out_valid, out_instr, in_ready, want[0]);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_instr !== want[i]) begin
        n_bad++;
        $display("FAIL bp_drain%0d: got valid=%b %h want 1 %h", i, out_valid, out_instr, want[i]);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    exp_enc += 3;
    n_cmp++;
    if (out_valid !== 1'b0 || enc_count !== 16'(exp_enc)) begin
      n_bad++;
      $display("FAIL bp_count: got valid=%b enc=%0d want 0/%0d", out_valid, enc_count, exp_enc);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_rd = 5'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_comb: got ready=%b valid=%b want 0/1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || enc_count !== 16'(exp_enc)) begin
      n_bad++;
      $display("FAIL flush_clear: got valid=%b enc=%0d want 0/%0d", out_valid, enc_count, exp_enc);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_s1: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w; logic e, lat;
    out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || enc_count !== 16'd0 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_async: got valid=%b %h enc=%0d err=%0d want 0 0 0 0", out_valid, out_instr, enc_count, err_count);
    end
    exp_enc = 0; exp_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    xfer(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, w, e, lat);
    exp_enc++;
    n_cmp++;
    if (w !== 32'hFFF1_0093 || enc_count !== 16'(exp_enc)) begin
      n_bad++;
      $display("FAIL rst_recover: got %h enc=%0d want fff10093 %0d", w, enc_count, exp_enc);
    end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_s_b();
    test_j_u_r();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Pipelined RV32I instruction-word assembler for the magic backend. It is the inverse of immediate extraction.
- Takes decoded fields (type, opcode, registers, functs, 32-bit immediate) and packs them into a 32-bit instruction word.
- Flags immediates that the chosen format cannot represent.
- Used by trace injection and self-check logic to regenerate instruction words from backend-side decoded state. Valid/ready on both sides, two-stage pipeline.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters (wrap modulo 2^CNT_W)

Ports:
- clk        input   1   clock, all state updates on rising edge
- rst        input   1   asynchronous active-high reset
- flush      input   1   synchronous pipeline clear
- in_valid   input   1   input fields valid
- in_ready   output  1   encoder can accept this cycle
- in_type    input   3   format code: 0=r, 1=i, 2=s, 3=b, 4=u, 5=j; 6,7 illegal
- in_opcode  input   7   opcode field
- in_rd      input   5   rd
- in_rs1     input   5   rs1
- in_rs2     input   5   rs2
- in_funct3  input   3   funct3
- in_funct7  input   7   funct7 (r only)
- in_imm     input   32  sign-extended immediate value, byte offset for b/j, full value for u
- out_valid  output  1   encoded word valid
- out_ready  input   1   consumer accepts
- out_instr  output  32  encoded instruction
- out_err    output  1   immediate unrepresentable or illegal type
- enc_count  output  CNT_W  completed output handshakes
- err_count  output  CNT_W  completed output handshakes with out_err=1

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. Reset mid-transfer discards all in-flight entries.
- Stage 1 registers the raw fields. Stage 2 registers the encoded word and err bit. out_* are driven directly from stage 2.
- s2_load = s1_valid && (!s2_valid || out_ready).
- in_ready = !flush && (!s1_valid || s2_load). This is combinational from out_ready; there is no combinational path from in_valid.
- Accept = in_valid && in_ready. Latency is 2 cycles: accepted at edge N, out_valid=1 after edge N+1.
- Throughput is 1/cycle when out_ready=1.
- While out_valid && !out_ready, out_instr and out_err hold stable. Stage 1 holds. in_ready=0 once both stages are full.
- flush=1: both valid bits clear at the next edge, no accept that cycle, counters unchanged. flush dominates a simultaneous output handshake: the word is presented, but the handshake is not counted and the entry is cleared.
- Encoding (bit lists are MSB to LSB):
  - r: funct7, rs2, rs1, funct3, rd, opcode. Imm ignored, err=0.
  - i: imm[11:0], rs1, funct3, rd, opcode. err if imm != sext(imm[11:0]).
  - s: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode. err as for i.
  - b: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode. err if imm != sext(imm[12:0]) or imm[0]=1.
  - u: imm[31:12], rd, opcode. err if imm[11:0] != 0.
  - j: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode. err if imm != sext(imm[20:0]) or imm[0]=1.
  - Type 6/7: err=1.
  - Whenever err=1, out_instr=32'h0.
- Counters: a handshake is out_valid && out_ready && !flush.
  - enc_count increments on every handshake.
  - err_count increments additionally when out_err=1.
  - Both wrap from 2^CNT_W-1 to 0.
- Simultaneous accept and output handshake with a full pipe: stage 2 loads from stage 1, and stage 1 loads the new input in the same edge with no bubble.

Test Plan:
- i, opcode 0x13, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF, out_ready=1 -> out_instr=0xFFF10093, err=0, out_valid exactly 2 cycles after accept, enc_count=1.
- s, opcode 0x23, rs1=10, rs2=5, f3=2, imm=8 -> 0x00552423; then b, opcode 0x63, rs1=rs2=0, imm=0xFFFFFFFC -> 0xFE000EE3.
- j, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF.
- Error cases, each -> out_instr=0, out_err=1, err_count +1:
  - i with imm=0x800
  - b with imm=6 odd-aligned variant imm=3
  - u with imm=0x12345001
  - type=7
- Backpressure: out_ready=0, 3 back-to-back valid inputs -> only 2 accepted, in_ready=0 on the 3rd, out_instr stable. Then out_ready=1 -> 3 words emerge in order on consecutive cycles, enc_count=3.
- Pipe full, flush=1 with out_ready=1 -> no handshake counted, out_valid=0 next cycle. Separately, rst asserted mid-stream between edges -> out_valid and counters 0 immediately, without waiting for a clock edge.
